// File: rtl/dequant_izigzag.sv
`default_nettype none
// ============================================================================
//  Module   : dequant_izigzag
//  Purpose  : Dequantizer and inverse-zigzag block assembler feeding an 8x8
//             IDCT. One signed coefficient per cycle arrives in JPEG zigzag
//             order. It is multiplied by its quant-table entry and saturated
//             to OUT_W bits. The result is then written into the raster slot
//             of a 64-entry assembly buffer. A completed block is moved into a
//             held flat output bus, which stays there until it is acknowledged.
//  Ports    : clk_i        rising-edge clock
//             rst_i        asynchronous active-high reset
//             coef_in_i    signed quantized coefficient (zigzag order)
//             coef_valid_i coefficient valid (transfer = valid & ready)
//             coef_last_i  end-of-block marker, qualified by a transfer
//             coef_ready_o assembler can accept a coefficient this cycle
//             q_table_i    64 quant entries, zigzag order, Q_W bits each
//             blk_out_o    64 dequantized coefficients, raster order
//             blk_valid_o  blk_out_o holds a complete block (level)
//             blk_ack_i    consumer has taken blk_out_o
//             blk_sat_o    presented block contained a saturated value
//  Revision : 1.0  initial release
// ============================================================================
module dequant_izigzag #(
  parameter int IN_W  = 11,
  parameter int Q_W   = 8,
  parameter int OUT_W = 11
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic signed [IN_W-1:0] coef_in_i,
  input  logic                   coef_valid_i,
  input  logic                   coef_last_i,
  output logic                   coef_ready_o,
  input  logic [64*Q_W-1:0]      q_table_i,
  output logic [64*OUT_W-1:0]    blk_out_o,
  output logic                   blk_valid_o,
  input  logic                   blk_ack_i,
  output logic                   blk_sat_o
);

  localparam int PROD_W = IN_W + Q_W + 1;

  // Saturation bounds, +(2^(OUT_W-1)-1) and -2^(OUT_W-1), built at product width
  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Zigzag position -> raster position (row*8+col)
  function automatic logic [5:0] zz_raster(input logic [5:0] k);
    logic [5:0] r;
    case (k)
      6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;   6'd5:  r = 6'd2;   6'd6:  r = 6'd3;   6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;  6'd9:  r = 6'd24;  6'd10: r = 6'd32;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd11;  6'd14: r = 6'd4;   6'd15: r = 6'd5;
      6'd16: r = 6'd12;  6'd17: r = 6'd19;  6'd18: r = 6'd26;  6'd19: r = 6'd33;
      6'd20: r = 6'd40;  6'd21: r = 6'd48;  6'd22: r = 6'd41;  6'd23: r = 6'd34;
      6'd24: r = 6'd27;  6'd25: r = 6'd20;  6'd26: r = 6'd13;  6'd27: r = 6'd6;
      6'd28: r = 6'd7;   6'd29: r = 6'd14;  6'd30: r = 6'd21;  6'd31: r = 6'd28;
      6'd32: r = 6'd35;  6'd33: r = 6'd42;  6'd34: r = 6'd49;  6'd35: r = 6'd56;
      6'd36: r = 6'd57;  6'd37: r = 6'd50;  6'd38: r = 6'd43;  6'd39: r = 6'd36;
      6'd40: r = 6'd29;  6'd41: r = 6'd22;  6'd42: r = 6'd15;  6'd43: r = 6'd23;
      6'd44: r = 6'd30;  6'd45: r = 6'd37;  6'd46: r = 6'd44;  6'd47: r = 6'd51;
      6'd48: r = 6'd58;  6'd49: r = 6'd59;  6'd50: r = 6'd52;  6'd51: r = 6'd45;
      6'd52: r = 6'd38;  6'd53: r = 6'd31;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  default: r = 6'd63;
    endcase
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]            state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic [OUT_W-1:0]      asm_q [64];
  logic [OUT_W-1:0]      asm_d [64];
  logic                  sat_acc_q, sat_acc_d;
  logic [64*OUT_W-1:0]   blk_out_q, blk_out_d;
  logic                  blk_valid_q, blk_valid_d;
  logic                  blk_sat_q, blk_sat_d;

  // --------------------------------------------------------------------------
  // Datapath: table lookup, single multiplier, saturation
  // --------------------------------------------------------------------------
  logic [Q_W-1:0]           q_tab [64];
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] q_ext;
  logic signed [PROD_W-1:0] prod;
  logic [OUT_W-1:0]         sat_val;
  logic                     this_sat;
  logic [64*OUT_W-1:0]      asm_flat;

  generate
    for (genvar k = 0; k < 64; k++) begin : g_qtab
      assign q_tab[k] = q_table_i[k*Q_W +: Q_W];
    end
  endgenerate

  // Quant entries are unsigned, so they are zero-extended; the product of an
  // IN_W signed and a (Q_W+1) signed operand always fits in PROD_W bits.
  assign coef_ext = {{(PROD_W-IN_W){coef_in_i[IN_W-1]}}, coef_in_i};
  assign q_ext    = {{(PROD_W-Q_W){1'b0}}, q_tab[idx_q]};
  assign prod     = coef_ext * q_ext;

  always_comb begin
    sat_val  = prod[OUT_W-1:0];
    this_sat = 1'b0;
    if (prod > SAT_MAX) begin
      sat_val  = SAT_MAX[OUT_W-1:0];
      this_sat = 1'b1;
    end else if (prod < SAT_MIN) begin
      sat_val  = SAT_MIN[OUT_W-1:0];
      this_sat = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake and block-completion control
  // --------------------------------------------------------------------------
  logic xfer;
  logic blk_end;
  logic load;
  logic sat_new;

  assign coef_ready_o = (state_q == ST_FILL);
  assign xfer         = coef_valid_i & coef_ready_o;
  assign blk_end      = xfer & (coef_last_i | (idx_q == 6'd63));

  // Output register is loaded when a block completes and the output is free
  // (or being freed this very cycle), or when a parked block is released.
  assign load = (blk_end & (~blk_valid_q | blk_ack_i)) |
                ((state_q == ST_HOLD) & blk_ack_i);

  assign sat_new = sat_acc_q | (xfer & this_sat);

  // Assembly buffer with the current write folded in, so a load on the final
  // coefficient's edge captures that coefficient too.
  always_comb begin
    asm_d = asm_q;
    if (xfer) begin
      asm_d[zz_raster(idx_q)] = sat_val;
    end
  end

  generate
    for (genvar i = 0; i < 64; i++) begin : g_pack
      assign asm_flat[i*OUT_W +: OUT_W] = asm_d[i];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sat_acc_d   = sat_acc_q;
    blk_out_d   = blk_out_q;
    blk_valid_d = blk_valid_q;
    blk_sat_d   = blk_sat_q;

    if (xfer) begin
      sat_acc_d = sat_new;
      // idx stays put on the final coefficient so a parked block keeps it
      if (!blk_end) begin
        idx_d = idx_q + 6'd1;
      end
    end

    if (blk_end && !load) begin
      state_d = ST_HOLD;
    end

    if (load) begin
      blk_out_d   = asm_flat;
      blk_valid_d = 1'b1;
      blk_sat_d   = sat_new;
      sat_acc_d   = 1'b0;
      idx_d       = 6'd0;
      state_d     = ST_FILL;
    end else if (blk_ack_i) begin
      blk_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      sat_acc_q   <= 1'b0;
      blk_out_q   <= '0;
      blk_valid_q <= 1'b0;
      blk_sat_q   <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        asm_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sat_acc_q   <= sat_acc_d;
      blk_out_q   <= blk_out_d;
      blk_valid_q <= blk_valid_d;
      blk_sat_q   <= blk_sat_d;
      // Buffer clears on a load: unwritten slots of the next block read as 0
      if (load) begin
        for (int i = 0; i < 64; i++) begin
          asm_q[i] <= '0;
        end
      end else begin
        asm_q <= asm_d;
      end
    end
  end

  assign blk_out_o   = blk_out_q;
  assign blk_valid_o = blk_valid_q;
  assign blk_sat_o   = blk_sat_q;

endmodule
`default_nettype wire
